// File: rtl/aes_subbytes_seq.sv
// rtl/aes_subbytes_seq.sv - byte-serial AES SubBytes/SubWord using one external combinational S-box
module aes_subbytes_seq #(
    parameter int NBYTES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [8*NBYTES-1:0]   in_data_i,
    input  logic                  in_encrypt_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [8*NBYTES-1:0]   out_data_o,
    output logic [7:0]            sbox_a_o,
    output logic                  sbox_encrypt_o,
    input  logic [7:0]            sbox_q_i,
    output logic                  busy_o
);

    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 mode_q, mode_d;
    logic [8*NBYTES-1:0]  data_q, data_d;
    logic [8*NBYTES-1:0]  res_q, res_d;
    logic                 last_byte;

    assign last_byte = (idx_q == IW'(NBYTES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b1;
            data_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        data_d      = data_q;
        res_d       = res_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        sbox_a_o    = 8'h00;
        case (state_q)
            IDLE: begin
                in_ready_o = !rst_i;
                if (in_valid_i) begin
                    data_d  = in_data_i;
                    mode_d  = in_encrypt_i;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_o   = 1'b1;
                sbox_a_o = data_q[{idx_q, 3'b000} +: 8];
                res_d[{idx_q, 3'b000} +: 8] = sbox_q_i;
                // idx parks on the last byte rather than wrapping
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sbox_encrypt_o = mode_q;
    assign out_data_o     = res_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// tb/tb_aes_subbytes_seq.sv - scoreboard bench for aes_subbytes_seq at NBYTES=4 and NBYTES=16
module tb_aes_subbytes_seq;

    localparam logic [7:0] FWD [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [7:0] inv [256];
    initial for (int i = 0; i < 256; i++) inv[FWD[i]] = 8'(i);

    logic         clk = 1'b0;
    logic         rst, in_valid, in_enc, out_ready, sel;
    logic [127:0] in_data;
    int           total = 0;
    int           bad = 0;

    logic         rdy4, ov4, e4, busy4;
    logic [31:0]  od4;
    logic [7:0]   a4, q4;
    logic         rdy16, ov16, e16, busy16;
    logic [127:0] od16;
    logic [7:0]   a16, q16;

    logic         v_rdy, v_ov, v_e, v_busy;
    logic [127:0] v_od;
    logic [7:0]   v_a;
    int           nb;

    logic [127:0] exp4_q [$];
    logic [127:0] exp16_q [$];

    always #5 clk = ~clk;

    assign q4  = e4  ? FWD[a4]  : inv[a4];
    assign q16 = e16 ? FWD[a16] : inv[a16];

    aes_subbytes_seq #(.NBYTES(4)) u4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid & ~sel), .in_ready_o(rdy4),
        .in_data_i(in_data[31:0]), .in_encrypt_i(in_enc), .out_valid_o(ov4),
        .out_ready_i(out_ready & ~sel), .out_data_o(od4), .sbox_a_o(a4),
        .sbox_encrypt_o(e4), .sbox_q_i(q4), .busy_o(busy4)
    );

    aes_subbytes_seq #(.NBYTES(16)) u16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid & sel), .in_ready_o(rdy16),
        .in_data_i(in_data), .in_encrypt_i(in_enc), .out_valid_o(ov16),
        .out_ready_i(out_ready & sel), .out_data_o(od16), .sbox_a_o(a16),
        .sbox_encrypt_o(e16), .sbox_q_i(q16), .busy_o(busy16)
    );

    always_comb begin
        v_rdy  = sel ? rdy16  : rdy4;
        v_ov   = sel ? ov16   : ov4;
        v_e    = sel ? e16    : e4;
        v_busy = sel ? busy16 : busy4;
        v_a    = sel ? a16    : a4;
        v_od   = sel ? od16   : {96'b0, od4};
        nb     = sel ? 16     : 4;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: pops on every output handshake
    always @(negedge clk) begin
        if (!rst && ov4 && out_ready && !sel) begin
            if (exp4_q.size() == 0) chk("unexpected_out4", 128'(od4), 128'hx);
            else chk("out_data4", 128'(od4), exp4_q.pop_front());
        end
        if (!rst && ov16 && out_ready && sel) begin
            if (exp16_q.size() == 0) chk("unexpected_out16", od16, 128'hx);
            else chk("out_data16", od16, exp16_q.pop_front());
        end
    end

    task automatic send(input logic [127:0] d, input logic e, input logic [127:0] exp, input int hold);
        int n;
        logic [127:0] held;
        step();
        in_valid = 1'b1; in_data = d; in_enc = e;
        n = 0;
        while (!v_rdy && n < 20) begin step(); n++; end
        chk("accept_ready", 128'(v_rdy), 128'(1));
        if (sel) exp16_q.push_back(exp); else exp4_q.push_back(exp);
        n = 0;
        do begin
            step(); n++;
            in_data = d ^ {16{8'hA5}};
            if (v_busy) begin
                chk("sbox_a_order", 128'(v_a), 128'(d[8*(n-1) +: 8]));
                chk("sbox_enc_busy", 128'(v_e), 128'(e));
            end
        end while (!v_ov && n < 40);
        in_valid = 1'b0;
        chk("latency", 128'(n), 128'(nb + 1));
        held = v_od;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 128'(v_ov), 128'(1));
            chk("hold_data", v_od, held);
            chk("hold_in_ready", 128'(v_rdy), 128'(0));
        end
        out_ready = 1'b1;
        step();
        chk("idle_in_ready", 128'(v_rdy), 128'(1));
        chk("idle_out_valid", 128'(v_ov), 128'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_enc = 1'b1; out_ready = 1'b0; sel = 1'b0; in_data = '0;
        repeat (3) step();
        chk("rst_rdy4", 128'(rdy4), 128'(0));
        chk("rst_rdy16", 128'(rdy16), 128'(0));
        chk("rst_ov", 128'({ov4, ov16, busy4, busy16}), 128'(0));
        chk("rst_od16", od16, 128'(0));
        chk("rst_a_enc", 128'({a4, e4, a16, e16}), 128'({8'h00, 1'b1, 8'h00, 1'b1}));
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 128'({rdy4, rdy16}), 128'(2'b11));

        sel = 1'b0;
        send(128'h5301_00FF, 1'b1, 128'hED7C_6316, 5);
        send(128'hED7C_6316, 1'b0, 128'h5301_00FF, 0);
        send(128'h193D_E3BE, 1'b1, 128'hD427_11AE, 1);
        send(128'hD427_11AE, 1'b0, 128'h193D_E3BE, 0);

        // Abort a block with reset during its second BUSY cycle
        step();
        in_valid = 1'b1; in_data = 128'h1122_3344; in_enc = 1'b0;
        step();
        in_valid = 1'b0;
        chk("abort_busy1", 128'(busy4), 128'(1));
        step();
        rst = 1'b1;
        step();
        chk("abort_busy", 128'(busy4), 128'(0));
        chk("abort_ov", 128'(ov4), 128'(0));
        chk("abort_od", 128'(od4), 128'(0));
        chk("abort_rdy_in_rst", 128'(rdy4), 128'(0));
        chk("abort_a_enc", 128'({a4, e4}), 128'({8'h00, 1'b1}));
        rst = 1'b0;
        #1;
        chk("abort_rdy", 128'(rdy4), 128'(1));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_out", 128'(ov4), 128'(0));
        end
        send(128'h0, 1'b1, 128'h6363_6363, 0);

        sel = 1'b1;
        send(128'h0, 1'b1, {16{8'h63}}, 2);
        send(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1,
             128'h76abd7fe_2b670130_c56f6bf2_7b777c63, 0);
        send(128'h76abd7fe_2b670130_c56f6bf2_7b777c63, 1'b0,
             128'h0f0e0d0c_0b0a0908_07060504_03020100, 0);

        repeat (3) step();
        chk("scoreboard4_empty", 128'(exp4_q.size()), 128'(0));
        chk("scoreboard16_empty", 128'(exp16_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
